// File: rtl/fifo_rd_pkg.sv
// Shared constants for the FIFO stream reader: default data width, output
// buffer occupancy encoding and transfer counter width.
package fifo_rd_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OCC_W      = 2;
    localparam int unsigned CNT_W      = 16;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_HALF  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read side plus valid/ready stream side of the reader, grouped as one bus.
interface fifo_stream_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    // master: the reader itself; slave: the FIFO and downstream consumer
    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer; head entry drives the stream data.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              read_clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic [OCC_W-1:0]  occ
);

    logic [OCC_W-1:0]  occ_nxt;
    logic [DATA_W-1:0] head_q, head_nxt;
    logic [DATA_W-1:0] tail_q, tail_nxt;
    logic              valid_nxt;

    // State and data registers
    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            occ    <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
            valid  <= 1'b0;
        end else begin
            occ    <= occ_nxt;
            head_q <= head_nxt;
            tail_q <= tail_nxt;
            valid  <= valid_nxt;
        end
    end

    // Occupancy transitions; the reader's credit check never pushes into FULL without a pop
    always_comb begin
        occ_nxt  = occ;
        head_nxt = head_q;
        tail_nxt = tail_q;
        case (occ)
            OCC_EMPTY: begin
                if (push) begin
                    head_nxt = din;
                    occ_nxt  = OCC_HALF;
                end
            end
            OCC_HALF: begin
                if (push && pop) begin
                    head_nxt = din;
                end else if (push) begin
                    tail_nxt = din;
                    occ_nxt  = OCC_FULL;
                end else if (pop) begin
                    occ_nxt  = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_nxt = tail_q;
                    if (push) begin
                        tail_nxt = din;
                    end else begin
                        occ_nxt  = OCC_HALF;
                    end
                end
            end
            default: occ_nxt = OCC_EMPTY;
        endcase
        valid_nxt = (occ_nxt != OCC_EMPTY);
    end

    assign dout = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains an async FIFO (registered read data) into a valid/ready stream with
// credit-based reads. Optional pop counter enabled by FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                     read_clk,
    input  logic                     reset,
    fifo_stream_reader_if.master     bus
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         xfer_cnt
`endif
);

    localparam int unsigned LVL_W = 3;

    logic             pend_q;
    logic             pop;
    logic             rd_en_c;
    logic [LVL_W-1:0] level_c;
    logic [OCC_W-1:0] occ;

    assign pop = bus.m_valid && bus.m_ready;

    // Buffer slots committed after this edge: held words plus the one in flight, minus the pop
    assign level_c = LVL_W'(occ) + LVL_W'(pend_q) - LVL_W'(pop);
    assign rd_en_c = reset && !bus.fifo_empty && (level_c < LVL_W'(2));
    assign bus.fifo_rd_en = rd_en_c;

    // A read accepted this cycle returns data next cycle
    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= rd_en_c;
        end
    end

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .read_clk (read_clk),
        .reset    (reset),
        .push     (pend_q),
        .pop      (pop),
        .din      (bus.fifo_data),
        .dout     (bus.m_data),
        .valid    (bus.m_valid),
        .occ      (occ)
    );

`ifdef FIFO_STREAM_READER_CNT_EN
    // Saturating pop counter; clear takes priority over a simultaneous pop
    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) begin
            xfer_cnt <= '0;
        end else if (cnt_clr) begin
            xfer_cnt <= '0;
        end else if (pop && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural async-FIFO source plus in-order stream expectations.
module tb_fifo_stream_reader;

    localparam int unsigned DW = 8;

    logic read_clk = 1'b0;
    logic reset    = 1'b1;

    fifo_stream_reader_if #(.DATA_W(DW)) bus ();

    // Source FIFO model: written by the bench, read by the DUT
    logic [DW-1:0] src_mem [0:4095];
    int            src_wr    = 0;
    int            src_rd    = 0;
    logic          src_block = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

`ifdef FIFO_STREAM_READER_CNT_EN
    logic        cnt_clr = 1'b0;
    logic [15:0] xfer_cnt;
`endif

    fifo_stream_reader #(.DATA_W(DW)) dut (
        .read_clk (read_clk),
        .reset    (reset),
        .bus      (bus)
`ifdef FIFO_STREAM_READER_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .xfer_cnt (xfer_cnt)
`endif
    );

    always #5 read_clk = ~read_clk;

    assign bus.fifo_empty = src_block || (src_rd == src_wr);

    // Registered read data; garbage on cycles without an accepted read
    always @(posedge read_clk) begin
        if (bus.fifo_rd_en && !bus.fifo_empty) begin
            bus.fifo_data <= src_mem[src_rd];
            src_rd        <= src_rd + 1;
        end else begin
            bus.fifo_data <= DW'($urandom);
        end
    end

    task automatic push_src(input logic [DW-1:0] w);
        src_mem[src_wr] = w;
        src_wr++;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge read_clk); #1;
            n_total++;
            if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.fifo_rd_en !== 1'b0)
                $display("FAIL reset: valid=%b data=%h rd_en=%b, want 0/00/0", bus.m_valid, bus.m_data, bus.fifo_rd_en);
            else n_pass++;
        end
        @(negedge read_clk);
        reset = 1'b1;
    endtask

    task automatic test_empty_hold();
        for (int c = 0; c < 20; c++) begin
            @(negedge read_clk);
            bus.m_ready = 1'($urandom);
            #1;
            n_total++;
            if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== 8'h00)
                $display("FAIL empty_hold c%0d: rd_en=%b valid=%b data=%h, want 0/0/00", c, bus.fifo_rd_en, bus.m_valid, bus.m_data);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] vals [3];
        logic          exp_rd, exp_v;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int c = 0; c < 6; c++) begin
            @(negedge read_clk);
            if (c == 0) begin
                push_src(8'h11); push_src(8'h22); push_src(8'h33);
                bus.m_ready = 1'b1;
            end
            #1;
            exp_rd = (c <= 2);
            exp_v  = (c >= 2 && c <= 4);
            n_total++;
            if (bus.fifo_rd_en !== exp_rd || bus.m_valid !== exp_v)
                $display("FAIL basic c%0d: rd_en=%b valid=%b, want %b/%b", c, bus.fifo_rd_en, bus.m_valid, exp_rd, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_total++;
                if (bus.m_data !== vals[c-2])
                    $display("FAIL basic_data c%0d: got %h want %h", c, bus.m_data, vals[c-2]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [4];
        int            rd_base;
        @(negedge read_clk);
        bus.m_ready = 1'b0;
        rd_base = src_rd;
        for (int i = 0; i < 4; i++) begin
            w[i] = DW'($urandom);
            push_src(w[i]);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge read_clk); #1;
        end
        n_total++;
        if (src_rd - rd_base != 2 || bus.m_valid !== 1'b1 || bus.m_data !== w[0])
            $display("FAIL backpressure_hold: reads=%0d valid=%b data=%h, want 2/1/%h", src_rd - rd_base, bus.m_valid, bus.m_data, w[0]);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge read_clk);
            bus.m_ready = 1'b1;
            #1;
            n_total++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== w[i])
                $display("FAIL backpressure_drain w%0d: valid=%b data=%h, want 1/%h", i, bus.m_valid, bus.m_data, w[i]);
            else n_pass++;
        end
        @(negedge read_clk); #1;
        n_total++;
        if (bus.m_valid !== 1'b0)
            $display("FAIL backpressure_end: valid=%b want 0", bus.m_valid);
        else n_pass++;
    endtask

    task automatic test_toggle();
        int dlv = 0;
        int rd_base;
        int base;
        rd_base = src_rd;
        base    = src_wr;
        for (int i = 0; i < 16; i++) push_src(DW'(i));
        for (int c = 0; c < 200 && dlv < 16; c++) begin
            @(negedge read_clk);
            bus.m_ready = ~bus.m_ready;
            #1;
            n_total++;
            if ((src_rd - rd_base) - dlv > 2)
                $display("FAIL toggle_occ c%0d: held=%0d want <=2", c, (src_rd - rd_base) - dlv);
            else n_pass++;
            if (bus.m_valid && bus.m_ready) begin
                n_total++;
                if (bus.m_data !== DW'(dlv))
                    $display("FAIL toggle_order: got %h want %h", bus.m_data, DW'(dlv));
                else n_pass++;
                dlv++;
            end
        end
        n_total++;
        if (dlv != 16 || src_wr - base != 16)
            $display("FAIL toggle_count: delivered %0d want 16", dlv);
        else n_pass++;
    endtask

    task automatic test_random();
        int            dlv = 0;
        int            base;
        int            rd_base;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;
        base    = src_wr;
        rd_base = src_rd;
        for (int c = 0; c < 300; c++) begin
            @(negedge read_clk);
            if ($urandom_range(1, 0) == 1) push_src(DW'($urandom));
            src_block   = ($urandom_range(3, 0) == 0);
            bus.m_ready = 1'($urandom);
            #1;
            n_total++;
            if ((src_rd - rd_base) - dlv > 2)
                $display("FAIL random_occ c%0d: held=%0d want <=2", c, (src_rd - rd_base) - dlv);
            else n_pass++;
            if (prev_stall) begin
                n_total++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data)
                    $display("FAIL random_stall c%0d: valid=%b data=%h want 1/%h", c, bus.m_valid, bus.m_data, prev_data);
                else n_pass++;
            end
            if (bus.m_valid && bus.m_ready) begin
                n_total++;
                if (bus.m_data !== src_mem[base + dlv])
                    $display("FAIL random_order #%0d: got %h want %h", dlv, bus.m_data, src_mem[base + dlv]);
                else n_pass++;
                dlv++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
        src_block = 1'b0;
        for (int c = 0; c < 60 && dlv < src_wr - base; c++) begin
            @(negedge read_clk);
            bus.m_ready = 1'b1;
            #1;
            if (bus.m_valid) begin
                n_total++;
                if (bus.m_data !== src_mem[base + dlv])
                    $display("FAIL random_drain #%0d: got %h want %h", dlv, bus.m_data, src_mem[base + dlv]);
                else n_pass++;
                dlv++;
            end
        end
        n_total++;
        if (dlv != src_wr - base)
            $display("FAIL random_count: delivered %0d want %0d", dlv, src_wr - base);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] nxt;
        for (int c = 0; c < 4; c++) begin
            @(negedge read_clk);
            if (c == 0) begin
                for (int i = 0; i < 8; i++) push_src(DW'($urandom));
                bus.m_ready = 1'b1;
            end
            #1;
        end
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.fifo_rd_en !== 1'b0)
            $display("FAIL reset_mid_async: valid=%b data=%h rd_en=%b want 0/00/0", bus.m_valid, bus.m_data, bus.fifo_rd_en);
        else n_pass++;
        @(negedge read_clk); #1;
        n_total++;
        if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0 || bus.fifo_empty !== 1'b0)
            $display("FAIL reset_mid_hold: rd_en=%b valid=%b empty=%b want 0/0/0", bus.fifo_rd_en, bus.m_valid, bus.fifo_empty);
        else n_pass++;
        @(negedge read_clk);
        reset = 1'b1;
        nxt   = src_mem[src_rd];
        #1;
        n_total++;
        if (bus.fifo_rd_en !== 1'b1)
            $display("FAIL reset_mid_resume: rd_en=%b want 1", bus.fifo_rd_en);
        else n_pass++;
        for (int c = 0; c < 10 && !bus.m_valid; c++) begin
            @(negedge read_clk); #1;
        end
        n_total++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== nxt)
            $display("FAIL reset_mid_next: valid=%b data=%h want 1/%h", bus.m_valid, bus.m_data, nxt);
        else n_pass++;
        for (int c = 0; c < 30 && (src_rd != src_wr || bus.m_valid); c++) begin
            @(negedge read_clk); #1;
        end
        n_total++;
        if (src_rd != src_wr || bus.m_valid !== 1'b0)
            $display("FAIL reset_mid_drain: left=%0d valid=%b want 0/0", src_wr - src_rd, bus.m_valid);
        else n_pass++;
    endtask

`ifdef FIFO_STREAM_READER_CNT_EN
    task automatic test_counter();
        int dlv = 0;
        @(negedge read_clk);
        cnt_clr = 1'b1;
        @(negedge read_clk);
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) push_src(DW'($urandom));
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20 && dlv < 5; c++) begin
            @(negedge read_clk); #1;
            if (bus.m_valid) dlv++;
        end
        @(negedge read_clk); #1;
        n_total++;
        if (xfer_cnt !== 16'd5)
            $display("FAIL cnt_five: got %0d want 5", xfer_cnt);
        else n_pass++;
        push_src(DW'($urandom));
        for (int c = 0; c < 10 && !bus.m_valid; c++) begin
            @(negedge read_clk); #1;
        end
        cnt_clr = 1'b1;
        @(negedge read_clk);
        cnt_clr = 1'b0;
        #1;
        n_total++;
        if (xfer_cnt !== 16'd0)
            $display("FAIL cnt_clr_wins: got %0d want 0", xfer_cnt);
        else n_pass++;
        bus.m_ready = 1'b0;
        push_src(DW'($urandom));
        for (int c = 0; c < 10 && !bus.m_valid; c++) begin
            @(negedge read_clk); #1;
        end
        force dut.xfer_cnt = 16'hFFFF;
        #1;
        release dut.xfer_cnt;
        bus.m_ready = 1'b1;
        @(negedge read_clk);
        bus.m_ready = 1'b0;
        #1;
        n_total++;
        if (xfer_cnt !== 16'hFFFF || bus.m_valid !== 1'b0)
            $display("FAIL cnt_saturate: cnt=%h valid=%b want ffff/0", xfer_cnt, bus.m_valid);
        else n_pass++;
    endtask
`endif

    initial begin
        bus.m_ready   = 1'b0;
        bus.fifo_data = '0;
        test_reset();
        test_empty_hold();
        bus.m_ready = 1'b0;
        test_basic();
        test_backpressure();
        test_toggle();
        test_random();
        test_reset_mid();
`ifdef FIFO_STREAM_READER_CNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
